// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter with hold tracking.
// Grants are sticky while the owner keeps requesting.
module rr_grant_arbiter #(
    parameter int N          = 8,
    parameter int IDW        = $clog2(N),
    parameter int HOLD_LIMIT = 255
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [0:N-1]   r,
    output logic [0:N-1]   g,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic [7:0]     hold_cnt,
    output logic           hold_err
);

    logic [0:N-1]   g_q, g_d;
    logic           gv_q, gv_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           keep;
    logic           found;
    logic [IDW-1:0] cand;

    // Hold the current owner, else scan from the agent after the last owner.
    always_comb begin
        g_d   = g_q;
        gv_d  = gv_q;
        id_d  = id_q;
        ptr_d = ptr_q;
        cnt_d = '0;
        err_d = err_q;
        found = 1'b0;
        cand  = '0;
        keep  = gv_q && r[id_q];
        if (keep) begin
            if (cnt_q != 8'hFF)
                cnt_d = cnt_q + 8'd1;
            else
                cnt_d = cnt_q;
            if (int'(cnt_q) >= HOLD_LIMIT)
                err_d = 1'b1;
        end else begin
            g_d  = '0;
            gv_d = 1'b0;
            id_d = '0;
            for (int k = 1; k <= N; k++) begin
                cand = IDW'((int'(ptr_q) + k) % N);
                if (!found && r[cand]) begin
                    found     = 1'b1;
                    g_d[cand] = 1'b1;
                    gv_d      = 1'b1;
                    id_d      = cand;
                    ptr_d     = cand;
                end
            end
        end
    end

    // State registers; pointer resets to the last agent so agent 0 goes first.
    always_ff @(posedge clock) begin
        if (reset) begin
            g_q   <= '0;
            gv_q  <= 1'b0;
            id_q  <= '0;
            ptr_q <= IDW'(N - 1);
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            g_q   <= g_d;
            gv_q  <= gv_d;
            id_q  <= id_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign g           = g_q;
    assign grant_valid = gv_q;
    assign grant_id    = id_q;
    assign hold_cnt    = cnt_q;
    assign hold_err    = err_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter.
// Each task drives a scenario and checks outputs inline.
module tb_rr_grant_arbiter;

    localparam int N = 8;

    logic         clock;
    logic         reset;
    logic [0:N-1] r;
    logic [0:N-1] g;
    logic         grant_valid;
    logic [2:0]   grant_id;
    logic [7:0]   hold_cnt;
    logic         hold_err;

    int checks = 0;
    int errors = 0;

    rr_grant_arbiter #(.N(N), .IDW(3), .HOLD_LIMIT(255)) dut (
        .clock       (clock),
        .reset       (reset),
        .r           (r),
        .g           (g),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .hold_cnt    (hold_cnt),
        .hold_err    (hold_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [0:N-1] onehot(input int i);
        logic [0:N-1] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        r = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (g !== 8'b0000_0000) begin
            errors++;
            $display("FAIL reset_g got %b want %b", g, 8'b0);
        end
        checks++;
        if (grant_valid !== 1'b0 || grant_id !== 3'd0) begin
            errors++;
            $display("FAIL reset_id got gv=%b id=%0d want 0/0",
                     grant_valid, grant_id);
        end
        checks++;
        if (hold_cnt !== 8'd0 || hold_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt got cnt=%0d err=%b want 0/0",
                     hold_cnt, hold_err);
        end
    endtask

    task automatic test_single();
        do_reset();
        r = 8'b1000_0000;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (g !== 8'b1000_0000 || grant_id !== 3'd0 ||
                grant_valid !== 1'b1 || hold_cnt !== 8'(k)) begin
                errors++;
                $display("FAIL single_%0d got g=%b id=%0d gv=%b cnt=%0d want g=10000000 id=0 gv=1 cnt=%0d",
                         k, g, grant_id, grant_valid, hold_cnt, k);
            end
        end
        r = '0;
        step();
        checks++;
        if (g !== 8'b0 || grant_valid !== 1'b0 || hold_cnt !== 8'd0) begin
            errors++;
            $display("FAIL single_idle got g=%b gv=%b cnt=%0d want 0/0/0",
                     g, grant_valid, hold_cnt);
        end
    endtask

    task automatic test_stable();
        do_reset();
        r = 8'b1111_1111;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (g !== 8'b1000_0000 || grant_id !== 3'd0) begin
                errors++;
                $display("FAIL stable_%0d got g=%b id=%0d want 10000000 id=0",
                         k, g, grant_id);
            end
        end
    endtask

    task automatic test_round_robin();
        int owner;
        int nxt;
        owner = 0;
        for (int k = 0; k < N; k++) begin
            r = ~onehot(owner);
            step();
            nxt = (owner + 1) % N;
            checks++;
            if (g !== onehot(nxt) || grant_id !== 3'(nxt) ||
                grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_%0d got g=%b id=%0d gv=%b want g=%b id=%0d gv=1",
                         k, g, grant_id, grant_valid, onehot(nxt), nxt);
            end
            owner = nxt;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        r = 8'b0000_0100;
        step();
        checks++;
        if (g !== 8'b0000_0100 || grant_id !== 3'd5) begin
            errors++;
            $display("FAIL wrap_own5 got g=%b id=%0d want 00000100 id=5",
                     g, grant_id);
        end
        r = 8'b0010_0000;
        step();
        checks++;
        if (g !== 8'b0010_0000 || grant_id !== 3'd2 ||
            grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_to2 got g=%b id=%0d gv=%b want 00100000 id=2 gv=1",
                     g, grant_id, grant_valid);
        end
    endtask

    task automatic test_hold();
        int bad;
        do_reset();
        r = 8'b0001_0000;
        step();
        checks++;
        if (g !== 8'b0001_0000 || hold_cnt !== 8'd0) begin
            errors++;
            $display("FAIL hold_start got g=%b cnt=%0d want 00010000 cnt=0",
                     g, hold_cnt);
        end
        bad = 0;
        for (int k = 1; k <= 254; k++) begin
            step();
            if (g !== 8'b0001_0000 || hold_cnt !== 8'(k) || hold_err !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_ramp got %0d bad cycles want 0", bad);
        end
        step();
        checks++;
        if (hold_cnt !== 8'd255 || hold_err !== 1'b0) begin
            errors++;
            $display("FAIL hold_255 got cnt=%0d err=%b want 255/0",
                     hold_cnt, hold_err);
        end
        step();
        checks++;
        if (hold_cnt !== 8'd255 || hold_err !== 1'b1 ||
            g !== 8'b0001_0000) begin
            errors++;
            $display("FAIL hold_err_rise got cnt=%0d err=%b g=%b want 255/1/00010000",
                     hold_cnt, hold_err, g);
        end
        step();
        checks++;
        if (hold_cnt !== 8'd255 || hold_err !== 1'b1 ||
            g !== 8'b0001_0000) begin
            errors++;
            $display("FAIL hold_sat got cnt=%0d err=%b g=%b want 255/1/00010000",
                     hold_cnt, hold_err, g);
        end
        r = '0;
        step();
        checks++;
        if (hold_err !== 1'b1 || hold_cnt !== 8'd0 ||
            grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_sticky got err=%b cnt=%0d gv=%b want 1/0/0",
                     hold_err, hold_cnt, grant_valid);
        end
    endtask

    task automatic test_reset_mid();
        r = 8'b0000_0010;
        step();
        checks++;
        if (g !== 8'b0000_0010 || grant_id !== 3'd6 || hold_err !== 1'b1) begin
            errors++;
            $display("FAIL mid_own6 got g=%b id=%0d err=%b want 00000010 id=6 err=1",
                     g, grant_id, hold_err);
        end
        step();
        reset = 1'b1;
        step();
        checks++;
        if (g !== 8'b0 || grant_valid !== 1'b0 || hold_cnt !== 8'd0 ||
            hold_err !== 1'b0 || grant_id !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset got g=%b gv=%b cnt=%0d err=%b id=%0d want all 0",
                     g, grant_valid, hold_cnt, hold_err, grant_id);
        end
        reset = 1'b0;
        step();
        checks++;
        if (g !== 8'b0000_0010 || grant_id !== 3'd6 ||
            grant_valid !== 1'b1 || hold_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_regrant got g=%b id=%0d gv=%b cnt=%0d want 00000010 id=6 gv=1 cnt=0",
                     g, grant_id, grant_valid, hold_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        r = '0;
        test_reset();
        test_single();
        test_stable();
        test_round_robin();
        test_wrap();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Registered round-robin arbiter for N requesting agents sharing one resource; produces the one-hot grant vector consumed by the arbiter property checker downstream.
- Grant is held while the owner keeps requesting (no revocation).
- Re-arbitration is round-robin starting after the last owner.
- Also reports the encoded owner and tracks how long the owner has held the grant, flagging agents that exceed the hold limit.

Parameters:
- N, 8, number of agents; 2..32.
- IDW, $clog2(N), width of the encoded grant id.
- HOLD_LIMIT, 255, maximum consecutive requested-and-granted cycles before hold_err is raised.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- r  in  [0:N-1]  request vector; r[i] is agent i's request.
- g  out  [0:N-1]  registered one-hot-or-zero grant vector; g[i] is agent i's grant.
- grant_valid  out  1  registered; equals |g.
- grant_id  out  IDW  registered index of the owner; 0 when grant_valid=0.
- hold_cnt  out  8  registered count of consecutive cycles with g[id]&r[id], saturating at 255.
- hold_err  out  1  sticky; set when an owner exceeds HOLD_LIMIT.

Behaviour:
- Reset (clock "clock", reset "reset", synchronous, active-high): g=0, grant_valid=0, grant_id=0, hold_cnt=0, hold_err=0, last-owner pointer=N-1, so agent 0 has first priority.
- Reset asserted mid-grant clears all of the above at the next edge. r is ignored while reset=1.
- Latency: g(t+1) is a function of r(t) and g(t) only; exactly one cycle request-to-grant. No combinational path from r to any output.
- Each edge, when not in reset:
  - Hold: if grant_valid and r[grant_id]=1, g, grant_id and the pointer are unchanged.
  - Re-arbitrate: else if |r, grant the first requesting agent found scanning from (pointer+1) mod N upward with wrap-around. Set g to that one-hot value, grant_id to its index, and pointer to that index.
  - Idle: else g=0, grant_valid=0, grant_id=0; the pointer keeps its last owner.
- Properties that follow:
  - g is always $onehot0.
  - g(t+1)[i]=1 implies r(t)[i]=1.
  - If r is one-hot, the next g equals r.
  - If r(t)=r(t-1), then g(t+1)=g(t), because the owner granted from r(t-1) is still requesting.
- Owner dropping r and another agent requesting in the same cycle: hand-off happens in one cycle with no idle gap.
- Hold counter:
  - Next hold_cnt = hold_cnt+1, saturating at 255, when grant_valid and r[grant_id].
  - Next hold_cnt = 0 otherwise, including on re-arbitration to a new owner.
- hold_err:
  - Set at the edge where hold_cnt >= HOLD_LIMIT and grant_valid and r[grant_id].
  - Stays 1 until reset.
  - Does not revoke the grant.
- r containing X is not handled; the upstream agents guarantee known values out of reset.

Test Plan:
- Reset, then r=8'b1000_0000 (agent 0) for 3 cycles -> g=8'b1000_0000, grant_id=0, grant_valid=1 from the first post-request edge; hold_cnt counts 0,1,2.
- r=8'b1111_1111 held 5 cycles after reset -> agent 0 granted and held all 5 cycles; no change while r is stable.
- Round-robin, all requesting, each owner dropping r for one cycle after its grant -> grant order 0,1,2,...,7,0; no cycle with grant_valid=0 between owners.
- Owner agent 5 drops while only agent 2 requests (r=8'b0010_0000) -> next g=8'b0010_0000, grant_id=2; pointer wrap from 5 to 2 verified.
- Agent 3 granted and requesting 257 consecutive cycles -> hold_cnt saturates at 255; hold_err rises after the 256th counted cycle and stays 1 after r drops; grant never revoked during the hold.
- Reset pulsed for 1 cycle while agent 6 holds the grant -> g=0, hold_cnt=0, hold_err=0 after that edge; with r still 8'b0000_0010, agent 6 regranted one cycle after reset deasserts.
